imm_ext_seq: RTL and testbench

//   Sequential immediate extender, the parametrised successor to the fixed 8->16 zero-extender.

---
 rtl/imm_ext_seq.sv | 145 ++++++++++++++
 tb/tb_imm_ext_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_seq.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ext_seq
//  Description : Sequential immediate extender. Collects IN_W-bit chunks,
//                most significant chunk first, and emits one OUT_W-bit
//                immediate that is zero- or sign-extended from the collected
//                width. When more chunks arrive than fit, the newest ones are
//                kept and an overflow flag is raised with the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_seq #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    // Number of chunks that fit in the result, and a counter wide enough to
    // represent one more than that so overflow can be detected.
    localparam int c_MAX_CH = OUT_W / IN_W;
    localparam int c_CNT_W  = $clog2(c_MAX_CH + 2);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_MAX_CH);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(c_MAX_CH + 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ACC  = 2'd1;
    localparam logic [1:0] c_S_HOLD = 2'd2;

    logic [1:0]          r_state;
    logic [OUT_W-1:0]    r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [OUT_W-1:0]    r_out_data;
    logic                r_ovf;

    logic                w_accept;
    logic [OUT_W-1:0]    w_acc_shift;
    logic [OUT_W-1:0]    w_acc_fresh;
    logic [OUT_W-1:0]    w_acc_next;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_CNT_W-1:0]  w_n_eff;
    logic [c_MAX_CH-1:0] w_keep;
    logic [c_MAX_CH-1:0] w_is_top;
    logic [c_MAX_CH-1:0] w_msb;
    logic                w_fill;
    logic [OUT_W-1:0]    w_ext;

    assign in_ready  = (r_state != c_S_HOLD);
    assign out_valid = (r_state == c_S_HOLD);
    assign out_data  = r_out_data;
    assign out_ovf   = r_ovf;

    assign w_accept  = in_valid & in_ready;

    // Shifted and restarted accumulator images; a single-chunk result has no
    // older chunks to shift and needs no zero padding.
    generate
        if (c_MAX_CH == 1) begin : g_single
            assign w_acc_shift = in_data;
            assign w_acc_fresh = in_data;
        end else begin : g_multi
            assign w_acc_shift = {r_acc[OUT_W-IN_W-1:0], in_data};
            assign w_acc_fresh = {{(OUT_W-IN_W){1'b0}}, in_data};
        end
    endgenerate

    // Next accumulator and saturating chunk count for an accepted chunk; a
    // chunk arriving in IDLE starts a fresh immediate.
    always_comb begin
        w_acc_next = w_acc_shift;
        w_cnt_next = r_cnt;
        if (r_state == c_S_IDLE) begin
            w_acc_next = w_acc_fresh;
            w_cnt_next = c_CNT_ONE;
        end else if (r_cnt != c_CNT_SAT) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end
    end

    // Chunks actually present in the result, capped at what fits.
    assign w_n_eff = (w_cnt_next > c_CNT_FULL) ? c_CNT_FULL : w_cnt_next;

    // Per-chunk extension: chunks below the collected width pass through,
    // chunks above it take the fill bit. The fill bit is the MSB of the
    // topmost collected chunk when sign-extending.
    generate
        for (genvar k = 0; k < c_MAX_CH; k++) begin : g_chunk
            assign w_keep[k]   = (w_n_eff > c_CNT_W'(k));
            assign w_is_top[k] = (w_n_eff == c_CNT_W'(k + 1));
            assign w_msb[k]    = w_acc_next[k*IN_W + IN_W - 1];
            assign w_ext[k*IN_W +: IN_W] = w_keep[k] ? w_acc_next[k*IN_W +: IN_W]
                                                     : {IN_W{w_fill}};
        end
    endgenerate

    assign w_fill = in_signed & (|(w_is_top & w_msb));

    // Collection state machine with registered result and overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        if (in_last) begin
                            r_state    <= c_S_HOLD;
                            r_out_data <= w_ext;
                            r_ovf      <= (w_cnt_next > c_CNT_FULL);
                        end else begin
                            r_state    <= c_S_ACC;
                        end
                    end
                end
                c_S_HOLD: begin
                    if (out_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_ext_seq
//  Description : Self-checking bench for imm_ext_seq with a result
//                scoreboard fed by a small reference model of chunk
//                collection and extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_seq;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Reference model state: every chunk of the current immediate, untruncated.
    logic [63:0] m_acc = '0;
    int          m_n   = 0;

    imm_ext_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one chunk and wait until it is accepted; on the last chunk the
    // model produces the expected result.
    task automatic send(input logic [7:0] d, input logic last, input logic sgn);
        int   waited;
        exp_t e;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_signed = sgn;
        waited    = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
        if (last) check_eq("no_early_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        in_last   = 1'($urandom);
        in_signed = 1'($urandom);
        if (m_n == 0) m_acc = {56'd0, d};
        else          m_acc = (m_acc << 8) | {56'd0, d};
        m_n++;
        if (last) begin
            if (m_n >= 2)  e.data = m_acc[15:0];
            else if (sgn)  e.data = {{8{m_acc[7]}}, m_acc[7:0]};
            else           e.data = {8'h00, m_acc[7:0]};
            e.ovf = (m_n > 2);
            sb.push_back(e);
            m_n = 0;
        end
    endtask

    // Accept pending results and confirm the block returns to accepting input.
    task automatic drain();
        int waited;
        out_ready = 1'b1;
        waited    = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        #1;
        out_ready = 1'b0;
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Scoreboard: compare a result whenever it is transferred.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check_eq("pending_results", 32'(sb.size()), 32'd1);
            if (out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out_data", 32'(out_data), 32'(e.data));
                check_eq("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Single chunks, zero- and sign-extended.
        send(8'h0F, 1'b1, 1'b0);
        check_eq("t1_valid_next", 32'(out_valid), 32'd1);
        drain();
        send(8'hF0, 1'b1, 1'b1);
        drain();
        send(8'hF0, 1'b1, 1'b0);
        drain();

        // Full width: sign request has no effect.
        send(8'h92, 1'b0, 1'b0);
        send(8'h34, 1'b1, 1'b1);
        drain();

        // Three chunks: oldest shifted out, overflow flagged.
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        drain();

        // Backpressure: result held, input ignored while holding.
        send(8'hA5, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            if (sb.size() > 0) check_eq("bp_out_data", 32'(out_data), 32'(sb[0].data));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-collection discards the partial immediate.
        send(8'h11, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_n   = 0;
        check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_out_data", 32'(out_data), 32'd0);
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd1);
        send(8'h80, 1'b1, 1'b1);
        drain();

        // Reset while a result is pending discards it.
        send(8'h42, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        reset = 1'b0;
        check_eq("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_hold_out_ovf", 32'(out_ovf), 32'd0);
        check_eq("rst_hold_in_ready", 32'(in_ready), 32'd1);

        // Random immediates of 1..4 chunks with idle gaps and stalls.
        for (int t = 0; t < 30; t++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int c = 0; c < n; c++) begin
                send(8'($urandom), (c == n - 1), 1'($urandom));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
